// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: redirect, imem handshake and instruction-stream bundle; FETCH_STATS_EN adds counter outputs
interface fetch_queue_unit_if;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] pcPlus8;
  logic [31:0] instrPc;
`ifdef FETCH_STATS_EN
  logic [31:0] statFetched;
  logic [31:0] statFlushed;
  modport master(
    input  pcSrc, pcTarget, imemAck, imemData, instrReady,
    output imemReq, imemAddr, instrValid, instr, pcPlus8, instrPc, statFetched, statFlushed
  );
  modport slave(
    output pcSrc, pcTarget, imemAck, imemData, instrReady,
    input  imemReq, imemAddr, instrValid, instr, pcPlus8, instrPc, statFetched, statFlushed
  );
`else
  modport master(
    input  pcSrc, pcTarget, imemAck, imemData, instrReady,
    output imemReq, imemAddr, instrValid, instr, pcPlus8, instrPc
  );
  modport slave(
    output pcSrc, pcTarget, imemAck, imemData, instrReady,
    input  imemReq, imemAddr, instrValid, instr, pcPlus8, instrPc
  );
`endif
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: ARM fetch front end with prefetch queue; FETCH_STATS_EN adds fetch/flush counters
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  fetch_queue_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, REQ} state_e;
  state_e        state_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic          disc_q;
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   pc_mem_q [DEPTH];
  logic          busy, pop, push, hold, issue;
  assign busy       = state_q == REQ;
  assign hold       = busy & ~bus.imemAck;
  assign pop        = bus.instrValid & bus.instrReady & ~bus.pcSrc;
  assign push       = busy & bus.imemAck & ~disc_q & ~bus.pcSrc;
  assign count_d    = bus.pcSrc ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign fetch_pc_d = bus.pcSrc ? bus.pcTarget & ~32'd3 : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
  // count_d already includes this cycle's push, so one more request keeps commitments within DEPTH
  assign issue      = ~hold & (count_d < (AW+1)'(DEPTH)) & ~(~busy & bus.pcSrc);
  assign addr_d     = hold ? addr_q : fetch_pc_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      disc_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= (hold | issue) ? REQ : IDLE;
      disc_q     <= hold & (disc_q | bus.pcSrc);
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      if (bus.pcSrc) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          data_mem_q[wr_ptr_q] <= bus.imemData;
          pc_mem_q[wr_ptr_q]   <= addr_q;
          wr_ptr_q             <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end
  assign bus.imemReq    = busy;
  assign bus.imemAddr   = addr_q;
  assign bus.instrValid = count_q != '0;
  assign bus.instr      = data_mem_q[rd_ptr_q];
  assign bus.instrPc    = pc_mem_q[rd_ptr_q];
  assign bus.pcPlus8    = pc_mem_q[rd_ptr_q] + 32'd8;
`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, flushed_q;
  logic [32:0] flush_sum;
  // a still-outstanding response not yet marked for discard is lost by this redirect
  assign flush_sum = {1'b0, flushed_q} + 33'(count_q) + 33'(busy & ~disc_q);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (push && fetched_q != '1) fetched_q <= fetched_q + 32'd1;
      if (bus.pcSrc) flushed_q <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
  assign bus.statFetched = fetched_q;
  assign bus.statFlushed = flushed_q;
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: scoreboard bench for fetch_queue_unit with a wait-state memory responder
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0, mismatched = 0, pops = 0;
  int mem_wait = 1;
  bit mem_rand = 1'b0;
  logic [31:0] exp_q [$];
  fetch_queue_unit_if bus();
  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input string n);
    bit ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (bus.imemReq && bus.imemAck) begin
        ok = 1'b1;
        break;
      end
    end
    chk({n, "_ack_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input int w, input bit rdy);
    rst = 1'b0;
    bus.pcSrc = 1'b0;
    bus.pcTarget = '0;
    bus.instrReady = rdy;
    mem_wait = w;
    mem_rand = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(bus.imemReq), 32'd0);
    chk("rst_addr", bus.imemAddr, 32'h0);
    chk("rst_valid", 32'(bus.instrValid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instrPc, 32'h0);
    chk("rst_pc8", bus.pcPlus8, 32'h8);
    rst = 1'b1;
  endtask

  // memory: acks after a configurable or random number of wait cycles
  initial begin
    int wc, cur;
    wc = 0;
    cur = 1;
    bus.imemAck = 1'b0;
    bus.imemData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || !bus.imemReq) begin
        bus.imemAck = 1'b0;
        wc = 0;
        cur = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
      end else if (wc >= cur) begin
        bus.imemAck = 1'b1;
        bus.imemData = word_at(bus.imemAddr);
        wc = 0;
        cur = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
      end else begin
        bus.imemAck = 1'b0;
        wc++;
      end
    end
  end

  // monitor: program-order model of the delivered stream plus request-hold protocol
  initial begin
    logic [31:0] e, prev_addr;
    bit prev_wait;
    prev_addr = '0;
    prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q = {32'h0};
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          chk("req_hold", 32'(bus.imemReq), 32'd1);
          chk("addr_hold", bus.imemAddr, prev_addr);
        end
        if (bus.instrValid && bus.instrReady && !bus.pcSrc) begin
          e = exp_q.pop_front();
          chk("stream_pc", bus.instrPc, e);
          chk("stream_instr", bus.instr, word_at(e));
          chk("stream_pc8", bus.pcPlus8, e + 32'd8);
          exp_q.push_back(e + 32'd4);
          pops++;
        end
        if (bus.pcSrc) begin
          exp_q.delete();
          exp_q.push_back(bus.pcTarget & ~32'd3);
        end
        prev_wait = bus.imemReq && !bus.imemAck;
        prev_addr = bus.imemAddr;
      end
    end
  end

  initial begin
    int acks, p0, exp_fl;
    bit ok;
    bus.pcSrc = 1'b0;
    bus.pcTarget = '0;
    bus.instrReady = 1'b0;
    // sequential fetch with one wait state
    do_reset(1, 1'b1);
    tick();
    chk("first_req", 32'(bus.imemReq), 32'd1);
    chk("first_addr", bus.imemAddr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_ack("seq");
      chk("seq_addr", bus.imemAddr, 32'(i * 4));
    end
    repeat (4) tick();
    // stall with zero-wait memory until full, then resume
    do_reset(0, 1'b0);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.imemReq && bus.imemAck) acks++;
    end
    chk("full_acks", 32'(acks), 32'd4);
    chk("full_req", 32'(bus.imemReq), 32'd0);
    bus.instrReady = 1'b1;
    wait_ack("resume");
    chk("resume_addr", bus.imemAddr, 32'h10);
    repeat (6) tick();
    // redirect with three queued entries and one outstanding request
    do_reset(1, 1'b0);
    repeat (3) wait_ack("fill");
    tick();
    chk("fill_addr", bus.imemAddr, 32'hC);
    bus.pcSrc = 1'b1;
    bus.pcTarget = 32'h0000_0103;
    tick();
    bus.pcSrc = 1'b0;
    chk("flush_valid", 32'(bus.instrValid), 32'd0);
    chk("flush_hold", bus.imemAddr, 32'hC);
    tick();
    chk("redir_req", 32'(bus.imemReq), 32'd1);
    chk("redir_addr", bus.imemAddr, 32'h100);
    bus.instrReady = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = bus.instrValid;
    end
    chk("redir_first_pc", bus.instrPc, 32'h100);
    repeat (4) tick();
    // redirect during a three-wait-state request
    do_reset(3, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = bus.imemReq && bus.imemAddr == 32'h20;
    end
    chk("reach_20", 32'(ok), 32'd1);
    tick();
    bus.pcSrc = 1'b1;
    bus.pcTarget = 32'h200;
    tick();
    bus.pcSrc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("wait_addr", bus.imemAddr, 32'h20);
      if (bus.imemAck) break;
      tick();
    end
    tick();
    chk("retarget_req", 32'(bus.imemReq), 32'd1);
    chk("retarget_addr", bus.imemAddr, 32'h200);
    repeat (8) tick();
    // redirect coinciding with ack and pop
    do_reset(1, 1'b0);
    repeat (3) wait_ack("pre");
    bus.instrReady = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = bus.imemReq && bus.imemAck && bus.instrValid;
    end
    chk("coincide_seen", 32'(ok), 32'd1);
    bus.pcSrc = 1'b1;
    bus.pcTarget = 32'h300;
    tick();
    bus.pcSrc = 1'b0;
    chk("coincide_valid", 32'(bus.instrValid), 32'd0);
    chk("coincide_req", 32'(bus.imemReq), 32'd1);
    chk("coincide_addr", bus.imemAddr, 32'h300);
    repeat (6) tick();
    // five accepted fetches, redirect with two queued plus one pending, then reset mid-request
    do_reset(1, 1'b1);
    p0 = pops;
    repeat (4) wait_ack("st");
    bus.instrReady = 1'b0;
    wait_ack("st5");
    tick();
    exp_fl = 5 - (pops - p0) + 1;
    bus.pcSrc = 1'b1;
    bus.pcTarget = 32'h40;
    tick();
    bus.pcSrc = 1'b0;
`ifdef FETCH_STATS_EN
    chk("stat_fetched", bus.statFetched, 32'd5);
    chk("stat_flushed", bus.statFlushed, 32'(exp_fl));
`endif
    tick();
    chk("st_addr", bus.imemAddr, 32'h40);
`ifdef FETCH_STATS_EN
    chk("stat_fetched_drop", bus.statFetched, 32'd5);
`endif
    rst = 1'b0;
    #1;
    chk("async_req", 32'(bus.imemReq), 32'd0);
    chk("async_valid", 32'(bus.instrValid), 32'd0);
`ifdef FETCH_STATS_EN
    chk("async_fetched", bus.statFetched, 32'd0);
    chk("async_flushed", bus.statFlushed, 32'd0);
`endif
    // randomized traffic, redirects and wait states
    do_reset(1, 1'b1);
    mem_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.instrReady = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) begin
        bus.pcSrc = 1'b1;
        bus.pcTarget = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      end else begin
        bus.pcSrc = 1'b0;
      end
      tick();
    end
    bus.pcSrc = 1'b0;
    repeat (10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
